// File: rtl/move_buffer_pkg.sv
// Shared constants for the move buffer: depth, field widths and packed record width.
package move_buffer_pkg;

  localparam int MOVE_BUFFER_BITS = 2;
  localparam int MOVE_DATA_W      = 64;

  // One record is {dir, duration, increment, incinc}.
  function automatic int move_rec_w(input int data_w);
    return 1 + 3 * data_w;
  endfunction

  localparam int MOVE_REC_W = move_rec_w(MOVE_DATA_W);

endpackage

// File: rtl/move_ram.sv
// Register-based dual-port store for move records: synchronous write, asynchronous read.
// The clr port gives a one-cycle wipe of every entry.
module move_ram #(
  parameter int AW = 2,
  parameter int W  = 193
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [2**AW];

  // NOTE: a memory is only worth clearing when it is built from flops; with a
  // small depth that is the case here, so a full wipe costs nothing extra.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/move_buffer.sv
// Show-ahead circular FIFO of move records between the SPI decoder and the DDA engine.
// Optional MOVE_BUFFER_OVERFLOW_EN adds a sticky overflow flag and a saturating drop counter.
module move_buffer
  import move_buffer_pkg::*;
#(
  parameter int DEPTH_BITS = MOVE_BUFFER_BITS,
  parameter int DATA_W     = MOVE_DATA_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_dir,
  input  logic [DATA_W-1:0]     wr_duration,
  input  logic [DATA_W-1:0]     wr_increment,
  input  logic [DATA_W-1:0]     wr_incinc,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_dir,
  output logic [DATA_W-1:0]     rd_duration,
  output logic [DATA_W-1:0]     rd_increment,
  output logic [DATA_W-1:0]     rd_incinc,
  input  logic                  flush,
  output logic [DEPTH_BITS:0]   count,
  output logic                  buffer_dtr
`ifdef MOVE_BUFFER_OVERFLOW_EN
  ,
  output logic                  overflow,
  output logic [7:0]            drop_count
`endif
);

  localparam int REC_W = move_rec_w(DATA_W);
  localparam logic [DEPTH_BITS:0] PTR_ONE = (DEPTH_BITS+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                full, empty, do_push, do_pop;
  logic [REC_W-1:0]    head;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]) &&
                   (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);
  assign do_push = wr_valid & ~full;
  assign do_pop  = rd_ready & ~empty;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  move_ram #(
    .AW (DEPTH_BITS),
    .W  (REC_W)
  ) u_ram (
    .clk   (clk),
    .clr   (~resetn),
    .we    (do_push & ~flush),
    .waddr (wr_ptr_q[DEPTH_BITS-1:0]),
    .wdata ({wr_dir, wr_duration, wr_increment, wr_incinc}),
    .raddr (rd_ptr_q[DEPTH_BITS-1:0]),
    .rdata (head)
  );

  assign {rd_dir, rd_duration, rd_increment, rd_incinc} = head;

  assign rd_valid   = ~empty;
  assign wr_ready   = ~full;
  assign buffer_dtr = ~full;
  assign count      = wr_ptr_q - rd_ptr_q;

`ifdef MOVE_BUFFER_OVERFLOW_EN
  logic       overflow_q, overflow_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (wr_valid && full) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_move_buffer.sv
// Directed self-checking bench for move_buffer: reset, single move, fill/drop,
// concurrent push/pop across pointer wrap, flush, pop-on-empty and mid-run reset.
module tb_move_buffer;

  localparam int DB = 2;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_dir;
  logic [DW-1:0] wr_duration;
  logic [DW-1:0] wr_increment;
  logic [DW-1:0] wr_incinc;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_dir;
  logic [DW-1:0] rd_duration;
  logic [DW-1:0] rd_increment;
  logic [DW-1:0] rd_incinc;
  logic          flush;
  logic [DB:0]   count;
  logic          buffer_dtr;
`ifdef MOVE_BUFFER_OVERFLOW_EN
  logic          overflow;
  logic [7:0]    drop_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  move_buffer #(.DEPTH_BITS(DB), .DATA_W(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_dir       (wr_dir),
    .wr_duration  (wr_duration),
    .wr_increment (wr_increment),
    .wr_incinc    (wr_incinc),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_dir       (rd_dir),
    .rd_duration  (rd_duration),
    .rd_increment (rd_increment),
    .rd_incinc    (rd_incinc),
    .flush        (flush),
    .count        (count),
    .buffer_dtr   (buffer_dtr)
`ifdef MOVE_BUFFER_OVERFLOW_EN
    ,
    .overflow     (overflow),
    .drop_count   (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] dur);
    wr_valid    = 1'b1;
    wr_dir      = dur[0];
    wr_duration = dur;
    tick();
    wr_valid    = 1'b0;
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    wr_dir = 1'b0; wr_duration = '0; wr_increment = '0; wr_incinc = '0;

    // 1. Reset
    tick(); tick();
    resetn = 1'b1;
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_dtr", buffer_dtr, 1);
    check("rst_rd_duration", rd_duration, 0);

    // 2. Single move
    wr_increment = 64'd5;
    wr_incinc    = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_valid = 1'b1; wr_dir = 1'b1; wr_duration = 64'd100;
    tick();
    wr_valid = 1'b0;
    check("single_rd_valid", rd_valid, 1);
    check("single_duration", rd_duration, 100);
    check("single_increment", rd_increment, 5);
    check("single_incinc", rd_incinc, 64'hFFFF_FFFF_FFFF_FFFF);
    check("single_dir", rd_dir, 1);
    check("single_count", count, 1);
    pop();
    check("single_pop_valid", rd_valid, 0);
    check("single_pop_count", count, 0);

    // 3. Fill, drop while full, drain in order
    for (int i = 1; i <= 4; i++) push(64'(i));
    check("fill_count", count, 4);
    check("fill_wr_ready", wr_ready, 0);
    check("fill_dtr", buffer_dtr, 0);
    push(64'd99);
    check("drop_count_stays", count, 4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", rd_valid, 1);
      check("drain_data", rd_duration, 64'(i));
      pop();
    end
    check("drain_empty", rd_valid, 0);
    check("drain_ready", wr_ready, 1);

    // 4. Concurrent push/pop at count=2; pointers wrap past 7 -> 0
    push(64'd10);
    push(64'd11);
    check("conc_start_count", count, 2);
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_duration = 64'(12 + k);
      check("conc_head", rd_duration, 64'(10 + k));
      tick();
      check("conc_count", count, 2);
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("conc_tail0", rd_duration, 20);
    pop();
    check("conc_tail1", rd_duration, 21);
    pop();
    check("conc_empty", count, 0);

    // 5. Flush with a same-cycle push
    push(64'd30); push(64'd31); push(64'd32);
    check("flush_pre_count", count, 3);
    flush = 1'b1; wr_valid = 1'b1; wr_duration = 64'd40;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_rd_valid", rd_valid, 0);
    push(64'd7);
    check("post_flush_data", rd_duration, 7);
    check("post_flush_count", count, 1);
    pop();

    // Pop while empty is ignored
    pop();
    check("pop_empty_count", count, 0);
    check("pop_empty_ready", wr_ready, 1);

    // Reset mid-operation with a same-cycle push and flush
    push(64'd50); push(64'd51);
    resetn = 1'b0; wr_valid = 1'b1; wr_duration = 64'd52; flush = 1'b1;
    tick();
    resetn = 1'b1; wr_valid = 1'b0; flush = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_valid", rd_valid, 0);
    check("midrst_data", rd_duration, 0);

`ifdef MOVE_BUFFER_OVERFLOW_EN
    // 6. Overflow flag and drop counter
    for (int i = 1; i <= 4; i++) push(64'(i));
    check("ovf_initial", overflow, 0);
    for (int i = 0; i < 3; i++) push(64'd88);
    check("ovf_set", overflow, 1);
    check("ovf_drops", drop_count, 3);
    check("ovf_head", rd_duration, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovf_flush_flag", overflow, 0);
    check("ovf_flush_drops", drop_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/move_buffer.md
Name: move_buffer

Overview:
- Circular FIFO of coordinated-move records between the SPI command decoder (producer) and the DDA step-timing engine (consumer).
- Replaces the toggle-latch stepready/stepfinished scheme with an explicit valid/ready handshake on both sides.
- Provides flush on HALT, occupancy count and the BUFFER_DTR flow-control level.
- Show-ahead: the head record is always presented on the rd_* outputs.

Parameters:
- DEPTH_BITS, 2, log2 of entry count (depth = 2**DEPTH_BITS = 4).
- DATA_W, 64, width of duration/increment/incrementincrement fields.

Ports:
- clk  in  1  system clock (CLK domain).
- resetn  in  1  synchronous active-low reset.
- wr_valid  in  1  producer presents a complete move record.
- wr_ready  out  1  buffer can accept a record (= !full).
- wr_dir  in  1  direction bit.
- wr_duration  in  DATA_W  move duration in DDA ticks.
- wr_increment  in  DATA_W  signed initial increment.
- wr_incinc  in  DATA_W  signed increment-of-increment.
- rd_valid  out  1  head record valid (= !empty).
- rd_ready  in  1  consumer pops the head this cycle.
- rd_dir  out  1  head direction.
- rd_duration  out  DATA_W  head duration.
- rd_increment  out  DATA_W  head increment.
- rd_incinc  out  DATA_W  head incrementincrement.
- flush  in  1  synchronous clear (HALT asserted, already active-high).
- count  out  DEPTH_BITS+1  occupancy, 0..2**DEPTH_BITS.
- buffer_dtr  out  1  host may send another move (= !full).

Behaviour:
- Storage: 2**DEPTH_BITS entries of {dir, duration, increment, incinc}.
- Pointers: wr_ptr and rd_ptr are DEPTH_BITS+1 wide; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal AND wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo 2**(DEPTH_BITS+1).
- Push: occurs on wr_valid & wr_ready at a rising edge; entry written at wr_ptr, wr_ptr increments.
- Pop: occurs on rd_valid & rd_ready; rd_ptr increments.
- wr_ready, rd_valid and buffer_dtr are derived from registered pointers only; no combinational path from wr_valid or rd_ready.
- Latency:
  - A record pushed at edge N is visible on rd_* with rd_valid=1 after edge N (cycle N+1).
  - After a pop, the next head appears the following cycle.
- rd_* outputs read memory at rd_ptr combinationally. Their value is don't-care while rd_valid=0, but the bench may check they are 0 after reset.
- Simultaneous push and pop:
  - Both occur when neither full nor empty; count unchanged.
  - When full, the push is blocked (wr_ready=0) and the pop proceeds.
  - When empty, the pop is blocked (rd_valid=0) and the push proceeds.
- Pointers wrap naturally modulo 2**(DEPTH_BITS+1); no special case at the wrap.
- Push while full: record dropped, pointers unchanged.
- Pop while empty: ignored.
- flush: wr_ptr <= rd_ptr <= 0 at the edge. It takes priority over a push or pop in the same cycle; that push is lost. Memory contents are not cleared.
- Reset (resetn=0 at an edge):
  - Pointers 0, count 0, rd_valid 0, wr_ready 1, buffer_dtr 1.
  - Memory cleared to 0, so rd_* read 0.
  - Reset mid-operation discards all entries; the same-cycle push/pop is ignored.
  - Reset dominates flush.

Optional Feature:
- Macro: MOVE_BUFFER_OVERFLOW_EN.
- Defined:
  - Extra ports overflow (out 1) and drop_count (out 8).
  - overflow is a sticky bit set on any wr_valid while full; drop_count saturates at 255.
  - Both are cleared by reset or flush.
- Undefined: the ports and logic are absent, and pushes while full are silently dropped.

Decomposition:
- Shared package/constants: MOVE_BUFFER_BITS (drives DEPTH_BITS), the record field widths, and the packed record width 1+3*DATA_W.
- One sub-module, move_ram: simple dual-port array, synchronous write, asynchronous read, no reset; top-level reset clearing is done by a reset write sweep or by register storage. Pick register storage for depth ≤ 8.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles, release -> count=0, rd_valid=0, wr_ready=1, buffer_dtr=1, rd_duration=0.
2. Single move: push {dir=1, dur=100, inc=5, incinc=-1} -> next cycle rd_valid=1, rd_duration=100, rd_incinc=-1, count=1. Pop -> rd_valid=0 next cycle.
3. Fill: push 4 records with dur=1..4 and no pops -> count=4, wr_ready=0, buffer_dtr=0. 5th push (dur=99) dropped. Pop sequence returns 1,2,3,4, never 99.
4. Concurrent: with count=2, hold wr_valid and rd_ready together for 10 cycles -> count stays 2. Pointers wrap past 7→0 and data order is preserved FIFO.
5. Flush: count=3, assert flush together with wr_valid -> next cycle count=0, rd_valid=0. A subsequent push of dur=7 reads back 7.
6. (MOVE_BUFFER_OVERFLOW_EN) Full buffer, 3 extra push attempts -> overflow=1, drop_count=3. flush -> both 0.
